// File: rtl/div_request_ctrl_pkg.sv
// Shared types for the RV32M divide requester: operation encoding, controller states
// and the conditional two's-complement helper used for sign fix-up.
package div_request_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } divctl_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic [31:0] negate_if(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divide core: operand magnitudes,
// locally-resolved special cases, and sign fix-up of core results.
module div_sign_fix
  import div_request_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        neg_q,
  output logic        neg_r,
  output logic        is_local,
  output logic [31:0] local_q,
  output logic [31:0] local_r,
  input  logic        fix_neg_q,
  input  logic        fix_neg_r,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic [31:0] fixed_q,
  output logic [31:0] fixed_r
);

  logic        sign_a;
  logic        sign_b;
  logic        by_zero;
  logic        overflow;
  logic        big_divisor;
  logic        a_ge_b;
  logic [31:0] big_q;
  logic [31:0] big_r;

  assign sign_a = is_signed & a[31];
  assign sign_b = is_signed & b[31];
  assign mag_a  = negate_if(a, sign_a);
  assign mag_b  = negate_if(b, sign_b);
  assign neg_q  = sign_a ^ sign_b;
  assign neg_r  = sign_a;

  assign by_zero     = (b == 32'd0);
  assign overflow    = is_signed && (a == INT_MIN) && (b == ALL_ONES);
  // A divisor magnitude of 2^31 or more yields a quotient of 0 or 1, so one compare suffices.
  assign big_divisor = mag_b[31];
  assign a_ge_b      = (mag_a >= mag_b);
  assign big_q       = {31'd0, a_ge_b};
  assign big_r       = a_ge_b ? (mag_a - mag_b) : mag_a;

  always_comb begin
    is_local = by_zero | overflow | big_divisor;
    local_q  = negate_if(big_q, neg_q);
    local_r  = negate_if(big_r, neg_r);
    if (by_zero) begin
      local_q = ALL_ONES;
      local_r = a;
    end else if (overflow) begin
      local_q = INT_MIN;
      local_r = 32'd0;
    end
  end

  assign fixed_q = negate_if(core_q, fix_neg_q);
  assign fixed_r = negate_if(core_r, fix_neg_r);

endmodule

// File: rtl/div_request_ctrl.sv
// Execute-stage front end for DIV/DIVU/REM/REMU: resolves special cases and cache hits
// locally, otherwise runs the calc/done handshake with the unsigned multicycle core.
module div_request_ctrl
  import div_request_ctrl_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_calc,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  divctl_state_t state_reg;
  div_op_t       op;
  logic          kill_reg;
  logic          rem_reg;
  logic          neg_q_reg;
  logic          neg_r_reg;
  logic [31:0]   key_a_reg;
  logic [31:0]   key_b_reg;
  logic          key_s_reg;
  logic          cache_valid_reg;
  logic [31:0]   cache_a_reg;
  logic [31:0]   cache_b_reg;
  logic          cache_s_reg;
  logic [31:0]   cache_q_reg;
  logic [31:0]   cache_r_reg;
  logic [31:0]   resp_data_reg;
  logic          div_calc_reg;
  logic [31:0]   dividend_reg;
  logic [31:0]   divisor_reg;

  logic          is_signed;
  logic          is_rem;
  logic          accept;
  logic          cache_hit;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic          neg_q;
  logic          neg_r;
  logic          is_local;
  logic [31:0]   local_q;
  logic [31:0]   local_r;
  logic [31:0]   fixed_q;
  logic [31:0]   fixed_r;

  assign op        = div_op_t'(req_op);
  assign is_signed = (op == OP_DIV) || (op == OP_REM);
  assign is_rem    = (op == OP_REM) || (op == OP_REMU);
  assign req_ready = (state_reg == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign cache_hit = CACHE_EN && cache_valid_reg && (cache_a_reg == req_a)
                     && (cache_b_reg == req_b) && (cache_s_reg == is_signed);

  div_sign_fix u_sign_fix (
    .a         (req_a),
    .b         (req_b),
    .is_signed (is_signed),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_q     (neg_q),
    .neg_r     (neg_r),
    .is_local  (is_local),
    .local_q   (local_q),
    .local_r   (local_r),
    .fix_neg_q (neg_q_reg),
    .fix_neg_r (neg_r_reg),
    .core_q    (div_quotient),
    .core_r    (div_remainder),
    .fixed_q   (fixed_q),
    .fixed_r   (fixed_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      kill_reg        <= 1'b0;
      rem_reg         <= 1'b0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      key_a_reg       <= '0;
      key_b_reg       <= '0;
      key_s_reg       <= 1'b0;
      cache_valid_reg <= 1'b0;
      cache_a_reg     <= '0;
      cache_b_reg     <= '0;
      cache_s_reg     <= 1'b0;
      cache_q_reg     <= '0;
      cache_r_reg     <= '0;
      resp_data_reg   <= '0;
      div_calc_reg    <= 1'b0;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
    end else begin
      div_calc_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (cache_hit) begin
              resp_data_reg <= is_rem ? cache_r_reg : cache_q_reg;
              state_reg     <= RESP;
            end else if (is_local) begin
              resp_data_reg <= is_rem ? local_r : local_q;
              state_reg     <= RESP;
            end else begin
              dividend_reg <= mag_a;
              divisor_reg  <= mag_b;
              neg_q_reg    <= neg_q;
              neg_r_reg    <= neg_r;
              rem_reg      <= is_rem;
              key_a_reg    <= req_a;
              key_b_reg    <= req_b;
              key_s_reg    <= is_signed;
              div_calc_reg <= 1'b1;
              state_reg    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush) kill_reg <= 1'b1;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            // Results are pure functions of the operands, so killed ops still fill the cache.
            cache_valid_reg <= CACHE_EN;
            cache_a_reg     <= key_a_reg;
            cache_b_reg     <= key_b_reg;
            cache_s_reg     <= key_s_reg;
            cache_q_reg     <= fixed_q;
            cache_r_reg     <= fixed_r;
            if (kill_reg || flush) begin
              kill_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              resp_data_reg <= rem_reg ? fixed_r : fixed_q;
              state_reg     <= RESP;
            end
          end else if (flush) begin
            kill_reg <= 1'b1;
          end
        end
        RESP: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid   = (state_reg == RESP) && !flush;
  assign resp_data    = resp_data_reg;
  assign div_calc     = div_calc_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;

endmodule

// File: tb/tb_div_request_ctrl.sv
// Randomized self-checking bench for div_request_ctrl with a behavioural divide core
// and an arithmetic RV32M reference model including the one-entry result cache.
module tb_div_request_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_calc;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;

  int checks = 0;
  int errors = 0;
  int calc_cnt = 0;
  int core_lat = 1;

  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_s = 1'b0;

  div_request_ctrl #(.CACHE_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_calc      (div_calc),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_calc === 1'b1) calc_cnt <= calc_cnt + 1;
  end

  // Behavioural unsigned core: answers a calc after core_lat cycles unless reset intervenes.
  initial begin
    logic [31:0] dd;
    logic [31:0] dv;
    logic        aborted;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (div_calc === 1'b1 && !rst) begin
        dd = div_dividend;
        dv = div_divisor;
        aborted = 1'b0;
        for (int i = 0; i < core_lat; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted && !rst) begin
          div_done      = 1'b1;
          div_quotient  = (dv == 0) ? 32'hFFFF_FFFF : dd / dv;
          div_remainder = (dv == 0) ? dd : dd % dv;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa;
    int signed sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic signed_op);
    return (signed_op && x[31]) ? 32'd0 - x : x;
  endfunction

  // mode: 0 normal, 1 flush while waiting on core, 2 flush during response, 3 reset while waiting
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode_in);
    logic [31:0] exp;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        sgn;
    logic        loc;
    logic        hit;
    logic        got_done;
    logic        early_ready;
    logic        stray_resp;
    int          n;
    int          cnt0;
    int          mode;
    mode = mode_in;
    sgn  = !op[0];
    exp  = ref_result(op, a, b);
    ma   = magnitude(a, sgn);
    mb   = magnitude(b, sgn);
    loc  = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (mb >= 32'h8000_0000);
    hit  = !loc && m_valid && m_a == a && m_b == b && m_s == sgn;
    if (mode == 2 && !(loc || hit)) mode = 0;
    if (mode == 1 || mode == 3) core_lat = int'($urandom_range(3, 6));
    else core_lat = int'($urandom_range(1, 4));
    $display("op=%0d a=%h b=%h exp=%h path=%s mode=%0d", op, a, b, exp,
             loc ? "local" : (hit ? "cache" : "core"), mode);

    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_before_accept", 32'(req_ready), 32'd1);
    cnt0 = calc_cnt;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;

    if (loc || hit) begin
      check_eq("no_calc_local", 32'(div_calc), 32'd0);
      if (mode == 2) begin
        flush = 1'b1;
        #1;
        check_eq("resp_flushed", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
      end else begin
        check_eq("resp_valid_fast", 32'(resp_valid), 32'd1);
        check_eq("resp_data_fast", resp_data, exp);
        @(posedge clk); #1;
      end
      check_eq("calc_count_local", 32'(calc_cnt - cnt0), 32'd0);
      return;
    end

    check_eq("calc_pulse", 32'(div_calc), 32'd1);
    check_eq("dividend", div_dividend, ma);
    check_eq("divisor", div_divisor, mb);

    if (mode == 3) begin
      #2 rst = 1'b1;
      #1;
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_data", resp_data, 32'd0);
      check_eq("rst_calc", 32'(div_calc), 32'd0);
      check_eq("rst_dividend", div_dividend, 32'd0);
      check_eq("rst_divisor", div_divisor, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_eq("ready_after_rst", 32'(req_ready), 32'd1);
      m_valid = 1'b0;
      return;
    end

    @(posedge clk); #1;
    check_eq("calc_one_cycle", 32'(div_calc), 32'd0);

    if (mode == 1) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      got_done = 1'b0;
      early_ready = 1'b0;
      stray_resp = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (resp_valid) stray_resp = 1'b1;
        if (div_done) begin
          got_done = 1'b1;
          break;
        end
        if (req_ready) early_ready = 1'b1;
        @(posedge clk); #1;
      end
      check_eq("flush_done_seen", 32'(got_done), 32'd1);
      check_eq("flush_ready_held", 32'(early_ready), 32'd0);
      check_eq("ready_after_done", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
        if (resp_valid) stray_resp = 1'b1;
        @(posedge clk); #1;
      end
      check_eq("killed_no_resp", 32'(stray_resp), 32'd0);
    end else begin
      n = 0;
      while (!resp_valid && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      check_eq("resp_valid_core", 32'(resp_valid), 32'd1);
      check_eq("resp_data_core", resp_data, exp);
      @(posedge clk); #1;
    end
    check_eq("calc_count_core", 32'(calc_cnt - cnt0), 32'd1);
    m_valid = 1'b1;
    m_a = a;
    m_b = b;
    m_s = sgn;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_resp_data", resp_data, 32'd0);
    check_eq("reset_calc", 32'(div_calc), 32'd0);
    check_eq("reset_dividend", div_dividend, 32'd0);
    check_eq("reset_divisor", div_divisor, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("reset_ready", 32'(req_ready), 32'd1);

    do_op(2'b01, 32'd100, 32'd7, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b00, 32'd5, 32'd0, 0);
    do_op(2'b11, 32'd5, 32'd0, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op(2'b01, 32'd12345, 32'd17, 1);
    do_op(2'b01, 32'd9, 32'd3, 0);
    do_op(2'b00, 32'hFFFF_FFB3, 32'd5, 3);
    do_op(2'b00, 32'hFFFF_FFB3, 32'd5, 0);
    do_op(2'b10, 32'hFFFF_FFB3, 32'd5, 2);

    // A request presented together with flush must not be taken.
    req_valid = 1'b1;
    req_op = 2'b01;
    req_a = 32'd40;
    req_b = 32'd6;
    flush = 1'b1;
    #1;
    check_eq("flush_idle_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    check_eq("flush_idle_no_calc", 32'(div_calc), 32'd0);
    check_eq("flush_idle_no_resp", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 150; i++) begin
      ra = pick();
      rb = pick();
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: do_op(rop, ra, rb, 1);
        1: do_op(rop, ra, rb, 2);
        default: do_op(rop, ra, rb, 0);
      endcase
      if ($urandom_range(0, 1) == 1) do_op(rop ^ 2'b10, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
